core_sequencer: RTL and testbench

Multi-cycle control FSM for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, sharing one memory port between instruction fetch and load/store. It consumes the instruction decoder's control outputs and drives the strobes for the IR, PC and register-file writes and the memory port. It also handles EBREAK halt/resume and a bounded memory-wait timeout fault.

---
 rtl/core_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_core_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the RV32I core: fetch/decode/execute/memory/writeback
// sequencing over a shared memory port, with EBREAK halt/resume and memory-wait timeout faults.
module core_sequencer #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mem_ready,
   input  logic       dec_mem_enable,
   input  logic       dec_mem_rw,
   input  logic [1:0] dec_r_w_src,
   input  logic [1:0] dec_bra_mode,
   input  logic       dec_brk,
   input  logic       dec_illegal,
   input  logic       cmp_taken,
   input  logic       resume,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_addr_sel,
   output logic       ir_load,
   output logic       reg_we,
   output logic       pc_we,
   output logic [1:0] pc_src,
   output logic       retire,
   output logic       halted,
   output logic       fault,
   output logic [1:0] fault_cause,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_FAULT  = 3'd6
   } state_t;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_FETCH   = 2'b10;
   localparam logic [1:0] CAUSE_DATA    = 2'b11;

   // Last wait-counter value at which a stalled request is still tolerated.
   localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

   state_t      cur_state;
   state_t      nxt_state;
   logic [15:0] wait_cnt;
   logic [15:0] wait_nxt;
   logic [1:0]  cause_q;
   logic [1:0]  cause_nxt;

   logic        req_c;
   logic        we_c;
   logic        irl_c;
   logic        rwe_c;
   logic        pwe_c;
   logic        ret_c;
   logic        asel_c;
   logic [1:0]  psrc_c;
   logic        in_mem_phase;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_state <= S_FETCH;
         wait_cnt  <= '0;
         cause_q   <= CAUSE_NONE;
      end else begin
         cur_state <= nxt_state;
         wait_cnt  <= wait_nxt;
         cause_q   <= cause_nxt;
      end
   end

   always_comb begin
      nxt_state = cur_state;
      cause_nxt = cause_q;
      req_c     = 1'b0;
      we_c      = 1'b0;
      irl_c     = 1'b0;
      rwe_c     = 1'b0;
      pwe_c     = 1'b0;
      ret_c     = 1'b0;
      asel_c    = 1'b0;
      psrc_c    = 2'd0;

      case (cur_state)
         S_FETCH: begin
            req_c = 1'b1;
            if (mem_ready) begin
               irl_c     = 1'b1;
               nxt_state = S_DECODE;
            end else if (wait_cnt == WAIT_LAST) begin
               nxt_state = S_FAULT;
               cause_nxt = CAUSE_FETCH;
            end
         end

         S_DECODE: begin
            if (dec_illegal) begin
               nxt_state = S_FAULT;
               cause_nxt = CAUSE_ILLEGAL;
            end else if (dec_brk) begin
               nxt_state = S_HALT;
            end else begin
               nxt_state = S_EXEC;
            end
         end

         S_EXEC: begin
            nxt_state = dec_mem_enable ? S_MEM : S_WB;
         end

         S_MEM: begin
            req_c  = 1'b1;
            asel_c = 1'b1;
            we_c   = dec_mem_rw;
            if (mem_ready) begin
               nxt_state = S_WB;
            end else if (wait_cnt == WAIT_LAST) begin
               nxt_state = S_FAULT;
               cause_nxt = CAUSE_DATA;
            end
         end

         S_WB: begin
            pwe_c     = 1'b1;
            ret_c     = 1'b1;
            // Stores carry a write source in some decodes but must never touch the register file.
            rwe_c     = (dec_r_w_src != 2'b00) && !(dec_mem_enable && dec_mem_rw);
            nxt_state = S_FETCH;
            case (dec_bra_mode)
               2'b00:   psrc_c = 2'd0;
               2'b01:   psrc_c = 2'd1;
               2'b10:   psrc_c = cmp_taken ? 2'd1 : 2'd0;
               default: psrc_c = 2'd2;
            endcase
         end

         S_HALT: begin
            // Resuming steps the PC past the EBREAK and counts it as retired.
            if (resume) begin
               pwe_c     = 1'b1;
               ret_c     = 1'b1;
               psrc_c    = 2'd0;
               nxt_state = S_FETCH;
            end
         end

         S_FAULT: begin
            nxt_state = S_FAULT;
         end

         default: begin
            nxt_state = S_FETCH;
         end
      endcase
   end

   // The counter only accumulates while a request stays stalled in the same state.
   assign in_mem_phase = (cur_state == S_FETCH) || (cur_state == S_MEM);

   always_comb begin
      wait_nxt = '0;
      if (in_mem_phase && !mem_ready && (nxt_state == cur_state)) begin
         wait_nxt = wait_cnt + 16'd1;
      end
   end

   assign mem_req      = rst_n & req_c;
   assign mem_we       = rst_n & we_c;
   assign ir_load      = rst_n & irl_c;
   assign reg_we       = rst_n & rwe_c;
   assign pc_we        = rst_n & pwe_c;
   assign retire       = rst_n & ret_c;
   assign mem_addr_sel = asel_c;
   assign pc_src       = psrc_c;
   assign halted       = (cur_state == S_HALT);
   assign fault        = (cur_state == S_FAULT);
   assign fault_cause  = cause_q;
   assign state        = cur_state;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: a driver queues hand-computed per-cycle output vectors,
// a monitor pops and compares them against the DUT each cycle.
module tb_core_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       mem_ready = 1'b0;
   logic       dec_mem_enable = 1'b0;
   logic       dec_mem_rw = 1'b0;
   logic [1:0] dec_r_w_src = 2'b00;
   logic [1:0] dec_bra_mode = 2'b00;
   logic       dec_brk = 1'b0;
   logic       dec_illegal = 1'b0;
   logic       cmp_taken = 1'b0;
   logic       resume = 1'b0;
   logic       mem_req;
   logic       mem_we;
   logic       mem_addr_sel;
   logic       ir_load;
   logic       reg_we;
   logic       pc_we;
   logic [1:0] pc_src;
   logic       retire;
   logic       halted;
   logic       fault;
   logic [1:0] fault_cause;
   logic [2:0] state;

   int total = 0;
   int bad   = 0;

   logic [15:0] exp_q[$];
   string       nm_q[$];

   core_sequencer #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .mem_ready(mem_ready),
      .dec_mem_enable(dec_mem_enable), .dec_mem_rw(dec_mem_rw),
      .dec_r_w_src(dec_r_w_src), .dec_bra_mode(dec_bra_mode),
      .dec_brk(dec_brk), .dec_illegal(dec_illegal), .cmp_taken(cmp_taken),
      .resume(resume), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr_sel(mem_addr_sel), .ir_load(ir_load), .reg_we(reg_we),
      .pc_we(pc_we), .pc_src(pc_src), .retire(retire), .halted(halted),
      .fault(fault), .fault_cause(fault_cause), .state(state)
   );

   always #5 clk = ~clk;

   // strb = {mem_req, mem_we, mem_addr_sel, ir_load, reg_we, pc_we}
   function automatic logic [15:0] mk(input logic [2:0] st, input logic [5:0] strb,
                                      input logic [1:0] psrc, input logic ret,
                                      input logic hlt, input logic flt, input logic [1:0] cause);
      return {st, strb, psrc, ret, hlt, flt, cause};
   endfunction

   task automatic step(input logic rst, input logic rdy, input logic rs,
                       input logic [15:0] e, input string nm);
      @(posedge clk);
      #1;
      rst_n     = rst;
      mem_ready = rdy;
      resume    = rs;
      exp_q.push_back(e);
      nm_q.push_back(nm);
   endtask

   task automatic set_dec(input logic men, input logic rw, input logic [1:0] rws,
                          input logic [1:0] bra, input logic brk, input logic ill,
                          input logic cmp);
      dec_mem_enable = men;
      dec_mem_rw     = rw;
      dec_r_w_src    = rws;
      dec_bra_mode   = bra;
      dec_brk        = brk;
      dec_illegal    = ill;
      cmp_taken      = cmp;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [15:0] e;
         logic [15:0] a;
         string       nm;
         e  = exp_q.pop_front();
         nm = nm_q.pop_front();
         a  = {state, mem_req, mem_we, mem_addr_sel, ir_load, reg_we, pc_we,
               pc_src, retire, halted, fault, fault_cause};
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL %s: got st=%0d strb=%b psrc=%0d ret=%b hlt=%b flt=%b cause=%b, want st=%0d strb=%b psrc=%0d ret=%b hlt=%b flt=%b cause=%b",
                     nm, a[15:13], a[12:7], a[6:5], a[4], a[3], a[2], a[1:0],
                     e[15:13], e[12:7], e[6:5], e[4], e[3], e[2], e[1:0]);
         end
      end
   end

   initial begin
      // reset
      step(0, 0, 0, mk(0, 6'b000000, 0, 0, 0, 0, 2'b00), "reset");

      // ADD: zero-wait, 4 cycles
      step(1, 1, 0, mk(0, 6'b100100, 0, 0, 0, 0, 2'b00), "add_fetch");
      set_dec(0, 0, 2'b01, 2'b00, 0, 0, 0);
      step(1, 1, 0, mk(1, 6'b000000, 0, 0, 0, 0, 2'b00), "add_decode");
      step(1, 1, 0, mk(2, 6'b000000, 0, 0, 0, 0, 2'b00), "add_exec");
      step(1, 1, 0, mk(4, 6'b000011, 0, 1, 0, 0, 2'b00), "add_wb");

      // load with 3 wait cycles in MEM (ready on the last allowed cycle)
      step(1, 1, 0, mk(0, 6'b100100, 0, 0, 0, 0, 2'b00), "ld_fetch");
      set_dec(1, 0, 2'b10, 2'b00, 0, 0, 0);
      step(1, 1, 0, mk(1, 6'b000000, 0, 0, 0, 0, 2'b00), "ld_decode");
      step(1, 1, 0, mk(2, 6'b000000, 0, 0, 0, 0, 2'b00), "ld_exec");
      for (int i = 0; i < 3; i++)
         step(1, 0, 0, mk(3, 6'b101000, 0, 0, 0, 0, 2'b00), "ld_mem_wait");
      step(1, 1, 0, mk(3, 6'b101000, 0, 0, 0, 0, 2'b00), "ld_mem_done");
      step(1, 1, 0, mk(4, 6'b000011, 0, 1, 0, 0, 2'b00), "ld_wb");

      // store: write strobe in MEM, no register write
      step(1, 1, 0, mk(0, 6'b100100, 0, 0, 0, 0, 2'b00), "st_fetch");
      set_dec(1, 1, 2'b10, 2'b00, 0, 0, 0);
      step(1, 1, 0, mk(1, 6'b000000, 0, 0, 0, 0, 2'b00), "st_decode");
      step(1, 1, 0, mk(2, 6'b000000, 0, 0, 0, 0, 2'b00), "st_exec");
      step(1, 1, 0, mk(3, 6'b111000, 0, 0, 0, 0, 2'b00), "st_mem");
      step(1, 1, 0, mk(4, 6'b000001, 0, 1, 0, 0, 2'b00), "st_wb");

      // conditional branch taken
      step(1, 1, 0, mk(0, 6'b100100, 0, 0, 0, 0, 2'b00), "bt_fetch");
      set_dec(0, 0, 2'b00, 2'b10, 0, 0, 1);
      step(1, 1, 0, mk(1, 6'b000000, 0, 0, 0, 0, 2'b00), "bt_decode");
      step(1, 1, 0, mk(2, 6'b000000, 0, 0, 0, 0, 2'b00), "bt_exec");
      step(1, 1, 0, mk(4, 6'b000001, 1, 1, 0, 0, 2'b00), "bt_wb");

      // conditional branch not taken
      step(1, 1, 0, mk(0, 6'b100100, 0, 0, 0, 0, 2'b00), "bn_fetch");
      set_dec(0, 0, 2'b00, 2'b10, 0, 0, 0);
      step(1, 1, 0, mk(1, 6'b000000, 0, 0, 0, 0, 2'b00), "bn_decode");
      step(1, 1, 0, mk(2, 6'b000000, 0, 0, 0, 0, 2'b00), "bn_exec");
      step(1, 1, 0, mk(4, 6'b000001, 0, 1, 0, 0, 2'b00), "bn_wb");

      // jump to ALU result with link
      step(1, 1, 0, mk(0, 6'b100100, 0, 0, 0, 0, 2'b00), "jr_fetch");
      set_dec(0, 0, 2'b11, 2'b11, 0, 0, 0);
      step(1, 1, 0, mk(1, 6'b000000, 0, 0, 0, 0, 2'b00), "jr_decode");
      step(1, 1, 0, mk(2, 6'b000000, 0, 0, 0, 0, 2'b00), "jr_exec");
      step(1, 1, 0, mk(4, 6'b000011, 2, 1, 0, 0, 2'b00), "jr_wb");

      // EBREAK: halt, hold with mem_ready high, then resume
      step(1, 1, 0, mk(0, 6'b100100, 0, 0, 0, 0, 2'b00), "brk_fetch");
      set_dec(0, 0, 2'b00, 2'b11, 1, 0, 0);
      step(1, 1, 0, mk(1, 6'b000000, 0, 0, 0, 0, 2'b00), "brk_decode");
      for (int i = 0; i < 10; i++)
         step(1, 1, 0, mk(5, 6'b000000, 0, 0, 1, 0, 2'b00), "halt_hold");
      step(1, 1, 1, mk(5, 6'b000001, 0, 1, 1, 0, 2'b00), "halt_resume");

      // fetch timeout: exactly 4 request cycles, then sticky fault
      for (int i = 0; i < 4; i++)
         step(1, 0, 0, mk(0, 6'b100000, 0, 0, 0, 0, 2'b00), "fto_fetch");
      for (int i = 0; i < 3; i++)
         step(1, 1, 1, mk(6, 6'b000000, 0, 0, 0, 1, 2'b10), "fto_fault");
      step(0, 1, 0, mk(6, 6'b000000, 0, 0, 0, 1, 2'b10), "fto_rst");
      step(1, 1, 0, mk(0, 6'b100100, 0, 0, 0, 0, 2'b00), "fto_recover");

      // illegal has priority over EBREAK
      set_dec(0, 0, 2'b00, 2'b00, 1, 1, 0);
      step(1, 1, 0, mk(1, 6'b000000, 0, 0, 0, 0, 2'b00), "ill_decode");
      for (int i = 0; i < 2; i++)
         step(1, 1, 0, mk(6, 6'b000000, 0, 0, 0, 1, 2'b01), "ill_fault");
      step(0, 1, 0, mk(6, 6'b000000, 0, 0, 0, 1, 2'b01), "ill_rst");

      // data timeout in MEM
      step(1, 1, 0, mk(0, 6'b100100, 0, 0, 0, 0, 2'b00), "dto_fetch");
      set_dec(1, 0, 2'b10, 2'b00, 0, 0, 0);
      step(1, 1, 0, mk(1, 6'b000000, 0, 0, 0, 0, 2'b00), "dto_decode");
      step(1, 1, 0, mk(2, 6'b000000, 0, 0, 0, 0, 2'b00), "dto_exec");
      for (int i = 0; i < 4; i++)
         step(1, 0, 0, mk(3, 6'b101000, 0, 0, 0, 0, 2'b00), "dto_mem");
      step(1, 0, 0, mk(6, 6'b000000, 0, 0, 0, 1, 2'b11), "dto_fault");
      step(0, 1, 0, mk(6, 6'b000000, 0, 0, 0, 1, 2'b11), "dto_rst");

      // reset asserted during WB suppresses retire and writes
      step(1, 1, 0, mk(0, 6'b100100, 0, 0, 0, 0, 2'b00), "mr_fetch");
      set_dec(0, 0, 2'b01, 2'b00, 0, 0, 0);
      step(1, 1, 0, mk(1, 6'b000000, 0, 0, 0, 0, 2'b00), "mr_decode");
      step(1, 1, 0, mk(2, 6'b000000, 0, 0, 0, 0, 2'b00), "mr_exec");
      step(0, 1, 0, mk(4, 6'b000000, 0, 0, 0, 0, 2'b00), "mr_wb_rst");
      step(1, 1, 0, mk(0, 6'b100100, 0, 0, 0, 0, 2'b00), "mr_fetch2");

      for (int i = 0; i < 5 && exp_q.size() > 0; i++)
         @(posedge clk);
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
